mesh_ext_endpoint: RTL and testbench

Host-side endpoint that connects to the `router_mesh` external port. The TX half packetizes host header and data requests into 64-bit head, body and tail flits and drives the mesh ext ingress. The RX half accepts flits from the mesh ext egress, checks packet framing and presents them to the host as a start/end-delimited stream. An optional watchdog flags egress stalls that exceed the 32-cycle handshake-progress bound used in mesh formal checks.

---
 rtl/mesh_ext_endpoint.sv | 198 +++++++++++++++++++
 tb/tb_mesh_ext_endpoint.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_ext_endpoint.sv
// rtl/mesh_ext_endpoint.sv - host endpoint for the router_mesh external port (TX packetizer, RX deframer)
// Optional egress-stall watchdog is built when MESH_EXT_WDOG_EN is defined.
module mesh_ext_endpoint #(
  parameter int FLIT_W      = 64,
  parameter int LEN_MAX     = 255,
  parameter int STALL_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_hdr_valid_i,
  output logic              tx_hdr_ready_o,
  input  logic [7:0]        tx_dest_i,
  input  logic [7:0]        tx_len_i,
  input  logic              tx_data_valid_i,
  output logic              tx_data_ready_o,
  input  logic [61:0]       tx_data_i,
  output logic [FLIT_W-1:0] mesh_flit_o,
  output logic              mesh_valid_o,
  input  logic              mesh_ready_i,
  input  logic [FLIT_W-1:0] mesh_flit_i,
  input  logic              mesh_valid_i,
  output logic              mesh_ready_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic [61:0]       rx_data_o,
  output logic              rx_sop_o,
  output logic              rx_eop_o,
  output logic              rx_err_o,
  output logic              stall_o,
  input  logic              stall_clr_i
);

  localparam int LEN_W = $clog2(LEN_MAX + 1);

  typedef enum logic {T_IDLE, T_BODY} tx_state_e;
  typedef enum logic {R_IDLE, R_PKT} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [7:0]        seq_q, seq_d;
  logic [FLIT_W-1:0] mesh_flit_q, mesh_flit_d;
  logic              mesh_valid_q, mesh_valid_d;
  logic              tx_free, hdr_fire, data_fire;

  assign tx_free         = !mesh_valid_q || mesh_ready_i;
  assign tx_hdr_ready_o  = (tx_state_q == T_IDLE) && tx_free;
  assign tx_data_ready_o = (tx_state_q == T_BODY) && tx_free;
  assign hdr_fire        = tx_hdr_valid_i && tx_hdr_ready_o;
  assign data_fire       = tx_data_valid_i && tx_data_ready_o;
  assign mesh_flit_o     = mesh_flit_q;
  assign mesh_valid_o    = mesh_valid_q;

  always_comb begin
    tx_state_d   = tx_state_q;
    rem_d        = rem_q;
    seq_d        = seq_q;
    mesh_flit_d  = mesh_flit_q;
    mesh_valid_d = mesh_valid_q;
    if (tx_free) mesh_valid_d = 1'b0;
    case (tx_state_q)
      T_IDLE: if (hdr_fire) begin
        seq_d        = seq_q + 8'd1;
        rem_d        = tx_len_i;
        mesh_valid_d = 1'b1;
        mesh_flit_d  = {(tx_len_i == 8'd0) ? 2'b11 : 2'b01, tx_dest_i, tx_len_i, seq_d, 38'd0};
        if (tx_len_i != 8'd0) tx_state_d = T_BODY;
      end
      T_BODY: if (data_fire) begin
        rem_d        = rem_q - LEN_W'(1);
        mesh_valid_d = 1'b1;
        mesh_flit_d  = {(rem_q == LEN_W'(1)) ? 2'b10 : 2'b00, tx_data_i};
        if (rem_q == LEN_W'(1)) tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q   <= T_IDLE;
      rem_q        <= '0;
      seq_q        <= '0;
      mesh_flit_q  <= '0;
      mesh_valid_q <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      rem_q        <= rem_d;
      seq_q        <= seq_d;
      mesh_flit_q  <= mesh_flit_d;
      mesh_valid_q <= mesh_valid_d;
    end
  end

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_valid_q, rx_valid_d;
  logic [61:0] rx_data_q, rx_data_d;
  logic        rx_sop_q, rx_sop_d, rx_eop_q, rx_eop_d;
  logic        rx_err_q, rx_err_d;
  logic        rx_accept;
  logic [1:0]  rx_type;

  assign mesh_ready_o = !rx_valid_q || rx_ready_i;
  assign rx_accept    = mesh_valid_i && mesh_ready_o;
  assign rx_type      = mesh_flit_i[63:62];
  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign rx_sop_o     = rx_sop_q;
  assign rx_eop_o     = rx_eop_q;
  assign rx_err_o     = rx_err_q;

  // rx_type[0] marks a head (01 or 11), rx_type[1] marks packet end (10 or 11)
  always_comb begin
    rx_state_d = rx_state_q;
    rx_valid_d = rx_valid_q && !rx_ready_i;
    rx_data_d  = rx_data_q;
    rx_sop_d   = rx_sop_q;
    rx_eop_d   = rx_eop_q;
    rx_err_d   = 1'b0;
    if (rx_accept) begin
      case (rx_state_q)
        R_IDLE: if (rx_type[0]) begin
          rx_valid_d = 1'b1;
          rx_data_d  = mesh_flit_i[61:0];
          rx_sop_d   = 1'b1;
          rx_eop_d   = rx_type[1];
          if (!rx_type[1]) rx_state_d = R_PKT;
        end else begin
          rx_err_d = 1'b1;
        end
        R_PKT: if (rx_type[0]) begin
          rx_err_d   = 1'b1;
          rx_state_d = R_IDLE;
        end else begin
          rx_valid_d = 1'b1;
          rx_data_d  = mesh_flit_i[61:0];
          rx_sop_d   = 1'b0;
          rx_eop_d   = rx_type[1];
          if (rx_type[1]) rx_state_d = R_IDLE;
        end
        default: rx_state_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= R_IDLE;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_sop_q   <= 1'b0;
      rx_eop_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_sop_q   <= rx_sop_d;
      rx_eop_q   <= rx_eop_d;
      rx_err_q   <= rx_err_d;
    end
  end

`ifdef MESH_EXT_WDOG_EN
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             stall_q, stall_d;

  always_comb begin
    wd_cnt_d = '0;
    stall_d  = stall_q;
    if (mesh_valid_q && !mesh_ready_i)
      wd_cnt_d = (wd_cnt_q == CNT_W'(STALL_LIMIT)) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
    if (wd_cnt_d == CNT_W'(STALL_LIMIT)) stall_d = 1'b1;
    if (stall_clr_i) begin
      wd_cnt_d = '0;
      stall_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_o = stall_q;
`else
  logic unused_wdog;
  assign unused_wdog = stall_clr_i ^ (STALL_LIMIT == 0);
  assign stall_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_ext_endpoint.sv
// tb/tb_mesh_ext_endpoint.sv - self-checking bench for mesh_ext_endpoint
// Directed and randomized TX/RX traffic against a packet-level reference model.
module tb_mesh_ext_endpoint;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_hdr_valid_i, tx_hdr_ready_o;
  logic [7:0]  tx_dest_i, tx_len_i;
  logic        tx_data_valid_i, tx_data_ready_o;
  logic [61:0] tx_data_i;
  logic [63:0] mesh_flit_o;
  logic        mesh_valid_o;
  logic        mesh_ready_i;
  logic [63:0] mesh_flit_i;
  logic        mesh_valid_i, mesh_ready_o;
  logic        rx_valid_o, rx_ready_i;
  logic [61:0] rx_data_o;
  logic        rx_sop_o, rx_eop_o, rx_err_o;
  logic        stall_o, stall_clr_i;

  logic use_rnd_tx = 1'b0, use_rnd_rx = 1'b0;
  logic mesh_ready_dir = 1'b1, rx_ready_dir = 1'b1;
  logic mesh_ready_rnd = 1'b1, rx_ready_rnd = 1'b1;
  assign mesh_ready_i = use_rnd_tx ? mesh_ready_rnd : mesh_ready_dir;
  assign rx_ready_i   = use_rnd_rx ? rx_ready_rnd : rx_ready_dir;

  int vectors = 0;
  int errs    = 0;

  logic [63:0] exp_tx[$], got_tx[$];
  logic [63:0] exp_rx[$], got_rx[$];
  int          exp_err = 0, got_err = 0;
  int          seq_m = 0;
  int          rem_m = 0;
  bit          in_pkt = 0;

  mesh_ext_endpoint dut (
    .clk(clk), .rst(rst),
    .tx_hdr_valid_i(tx_hdr_valid_i), .tx_hdr_ready_o(tx_hdr_ready_o),
    .tx_dest_i(tx_dest_i), .tx_len_i(tx_len_i),
    .tx_data_valid_i(tx_data_valid_i), .tx_data_ready_o(tx_data_ready_o),
    .tx_data_i(tx_data_i),
    .mesh_flit_o(mesh_flit_o), .mesh_valid_o(mesh_valid_o), .mesh_ready_i(mesh_ready_i),
    .mesh_flit_i(mesh_flit_i), .mesh_valid_i(mesh_valid_i), .mesh_ready_o(mesh_ready_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .rx_sop_o(rx_sop_o), .rx_eop_o(rx_eop_o), .rx_err_o(rx_err_o),
    .stall_o(stall_o), .stall_clr_i(stall_clr_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    mesh_ready_rnd = ($urandom_range(0, 3) != 0);
    rx_ready_rnd   = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mesh_valid_o && mesh_ready_i) got_tx.push_back(mesh_flit_o);
      if (rx_valid_o && rx_ready_i) got_rx.push_back({rx_sop_o, rx_eop_o, rx_data_o});
      if (rx_err_o) got_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_head(input logic [7:0] d, input logic [7:0] l, input logic [7:0] s);
    return {(l == 8'd0) ? 2'b11 : 2'b01, d, l, s, 38'd0};
  endfunction

  task automatic tx_hdr(input logic [7:0] d, input logic [7:0] l);
    bit done = 0;
    int n = 0;
    tx_hdr_valid_i = 1'b1;
    tx_dest_i      = d;
    tx_len_i       = l;
    while (!done && n < 500) begin
      @(negedge clk);
      done = tx_hdr_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    tx_hdr_valid_i = 1'b0;
    chk("tx_hdr_handshake", 64'(done), 64'd1);
    seq_m = (seq_m + 1) % 256;
    rem_m = l;
    exp_tx.push_back(mk_head(d, l, 8'(seq_m)));
  endtask

  task automatic tx_data(input logic [61:0] w);
    bit done = 0;
    int n = 0;
    tx_data_valid_i = 1'b1;
    tx_data_i       = w;
    while (!done && n < 500) begin
      @(negedge clk);
      done = tx_data_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    tx_data_valid_i = 1'b0;
    chk("tx_data_handshake", 64'(done), 64'd1);
    exp_tx.push_back({(rem_m == 1) ? 2'b10 : 2'b00, w});
    rem_m--;
  endtask

  task automatic rx_send(input logic [63:0] f);
    bit done = 0;
    int n = 0;
    mesh_valid_i = 1'b1;
    mesh_flit_i  = f;
    while (!done && n < 500) begin
      @(negedge clk);
      done = mesh_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    mesh_valid_i = 1'b0;
    chk("rx_handshake", 64'(done), 64'd1);
    // packet-level framing model: a head starts a packet, a tail ends it
    if (!in_pkt) begin
      if (f[62]) begin
        exp_rx.push_back({1'b1, f[63], f[61:0]});
        in_pkt = !f[63];
      end else exp_err++;
    end else if (f[62]) begin
      exp_err++;
      in_pkt = 0;
    end else begin
      exp_rx.push_back({1'b0, f[63], f[61:0]});
      if (f[63]) in_pkt = 0;
    end
  endtask

  function automatic logic [61:0] rnd62();
    return 62'({$urandom(), $urandom()});
  endfunction

  initial begin
    logic [61:0] a, b, c;
    logic [63:0] head, f;
    int len;
    rst = 1'b1;
    tx_hdr_valid_i = 0; tx_dest_i = 0; tx_len_i = 0;
    tx_data_valid_i = 0; tx_data_i = 0;
    mesh_flit_i = 0; mesh_valid_i = 0; stall_clr_i = 0;
    repeat (3) step();
    chk("rst_mesh_valid", 64'(mesh_valid_o), 64'd0);
    chk("rst_mesh_flit", mesh_flit_o, 64'd0);
    chk("rst_rx_valid", 64'(rx_valid_o), 64'd0);
    chk("rst_rx_data", 64'(rx_data_o), 64'd0);
    chk("rst_rx_flags", {61'd0, rx_sop_o, rx_eop_o, rx_err_o}, 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_mesh_ready", 64'(mesh_ready_o), 64'd1);
    chk("rst_hdr_ready", 64'(tx_hdr_ready_o), 64'd1);
    chk("rst_data_ready", 64'(tx_data_ready_o), 64'd0);
    rst = 1'b0;
    step();

    // single-flit packet, seq starts at 1
    tx_hdr(8'h21, 8'd0);
    chk("t1_valid", 64'(mesh_valid_o), 64'd1);
    chk("t1_flit", mesh_flit_o, {2'b11, 8'h21, 8'd0, 8'd1, 38'd0});
    step();
    chk("t1_drained", 64'(mesh_valid_o), 64'd0);

    // len=3 at full rate
    a = rnd62(); b = rnd62(); c = rnd62();
    tx_hdr(8'h34, 8'd3);
    chk("t2_head", mesh_flit_o, {2'b01, 8'h34, 8'd3, 8'd2, 38'd0});
    chk("t2_hdr_rdy_h", 64'(tx_hdr_ready_o), 64'd0);
    tx_data(a);
    chk("t2_a", mesh_flit_o, {2'b00, a});
    chk("t2_hdr_rdy_a", 64'(tx_hdr_ready_o), 64'd0);
    tx_data(b);
    chk("t2_b", mesh_flit_o, {2'b00, b});
    chk("t2_hdr_rdy_b", 64'(tx_hdr_ready_o), 64'd0);
    tx_data(c);
    chk("t2_c", mesh_flit_o, {2'b10, c});
    chk("t2_hdr_rdy_c", 64'(tx_hdr_ready_o), 64'd1);
    step();

    // 5-cycle backpressure mid-packet
    a = rnd62(); b = rnd62();
    tx_hdr(8'h7f, 8'd2);
    head = mk_head(8'h7f, 8'd2, 8'd3);
    mesh_ready_dir = 1'b0;
    tx_data_valid_i = 1'b1;
    tx_data_i = a;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_flit", mesh_flit_o, head);
      chk("t3_hold_valid", 64'(mesh_valid_o), 64'd1);
      chk("t3_hold_drdy", 64'(tx_data_ready_o), 64'd0);
    end
    mesh_ready_dir = 1'b1;
    tx_data(a);
    chk("t3_a", mesh_flit_o, {2'b00, a});
    tx_data(b);
    chk("t3_b", mesh_flit_o, {2'b10, b});
    step();

    // randomized packets under random backpressure
    use_rnd_tx = 1'b1;
    for (int p = 0; p < 14; p++) begin
      len = $urandom_range(0, 6);
      tx_hdr(8'($urandom()), 8'(len));
      for (int k = 0; k < len; k++) tx_data(rnd62());
    end
    use_rnd_tx = 1'b0;
    repeat (4) step();
    chk("tx_idle_after_drain", 64'(mesh_valid_o), 64'd0);

    // egress stall watchdog
    tx_hdr(8'h55, 8'd0);
    mesh_ready_dir = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 31) chk("wd_before_limit", 64'(stall_o), 64'd0);
    end
`ifdef MESH_EXT_WDOG_EN
    chk("wd_at_limit", 64'(stall_o), 64'd1);
`else
    chk("wd_disabled", 64'(stall_o), 64'd0);
`endif
    stall_clr_i = 1'b1;
    step();
    stall_clr_i = 1'b0;
    chk("wd_cleared", 64'(stall_o), 64'd0);
    mesh_ready_dir = 1'b1;
    repeat (2) step();

    chk("tx_count", 64'(got_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      chk($sformatf("tx_flit_%0d", i), got_tx[i], exp_tx[i]);

    // RX: head, body, tail
    a = rnd62(); b = rnd62(); c = rnd62();
    rx_send({2'b01, a});
    chk("r1_head", {rx_valid_o, rx_sop_o, rx_eop_o, rx_err_o, rx_data_o}, {4'b1100, a});
    rx_send({2'b00, b});
    chk("r1_body", {rx_valid_o, rx_sop_o, rx_eop_o, rx_err_o, rx_data_o}, {4'b1000, b});
    rx_send({2'b10, c});
    chk("r1_tail", {rx_valid_o, rx_sop_o, rx_eop_o, rx_err_o, rx_data_o}, {4'b1010, c});
    step();

    // RX framing errors: stray body, head, then a second head
    rx_send({2'b00, rnd62()});
    chk("r2_err1", {62'd0, rx_err_o, rx_valid_o}, 64'b10);
    a = rnd62();
    rx_send({2'b01, a});
    chk("r2_head", {rx_valid_o, rx_sop_o, rx_eop_o, rx_err_o, rx_data_o}, {4'b1100, a});
    rx_send({2'b01, rnd62()});
    chk("r2_err2", {62'd0, rx_err_o, rx_valid_o}, 64'b10);
    step();
    chk("r2_err_pulse", 64'(rx_err_o), 64'd0);

    // randomized RX traffic with random host backpressure
    use_rnd_rx = 1'b1;
    for (int i = 0; i < 80; i++) begin
      f = {2'($urandom_range(0, 3)), rnd62()};
      if ($urandom_range(0, 3) != 0) f[63:62] = in_pkt ? 2'($urandom_range(0, 2) == 0 ? 2 : 0) : 2'b01;
      rx_send(f);
    end
    use_rnd_rx = 1'b0;
    repeat (3) step();

    chk("rx_count", 64'(got_rx.size()), 64'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++)
      chk($sformatf("rx_out_%0d", i), got_rx[i], exp_rx[i]);
    chk("rx_err_count", 64'(got_err), 64'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
